if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, the bubble instruction (addi x0,x0,0).
REQ-003 clk  input  1  rising-edge clock; the block has one clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PCWrite  input  1  from the hazard unit; 1 allows the PC to advance.
REQ-006 IF_ID_Write  input  1  from the hazard unit; 1 allows the IF/ID register to load.
REQ-007 IF_Flush  input  1  from the hazard unit; a taken branch: squash the fetch and redirect.
REQ-008 BranchTarget  input  32  redirect address, sampled when IF_Flush=1.
REQ-009 imem_req  output  1  instruction-memory request.
REQ-010 imem_addr  output  32  request address; equals PC.
REQ-011 imem_ack  input  1  memory returns imem_rdata for imem_addr in the same cycle.
REQ-012 imem_rdata  input  32  fetched instruction.
REQ-013 IF_ID_PC  output  32  registered PC of the decode-stage instruction.
REQ-014 IF_ID_Instr  output  32  registered decode-stage instruction.
REQ-015 IF_ID_Valid  output  1  1 = IF_ID_Instr is real; 0 = bubble.
REQ-016 fetch_busy  output  1  1 while in REQ and no ack has arrived this cycle.

Function
REQ-017 The FSM SHALL have two states: REQ (imem_req=1) and HOLD (imem_req=0, fetched instruction parked in a 32-bit buffer with its PC).
REQ-018 Event priority SHALL be: reset > IF_Flush > stall > normal operation.
REQ-019 On IF_Flush=1 in any state: PC<=BranchTarget, IF_ID_Instr<=NOP_INSTR, IF_ID_Valid<=0, buffer discarded, state<=REQ; any same-cycle imem_ack data is dropped.
REQ-020 In REQ with imem_ack=1 and IF_ID_Write=1: IF_ID_Instr<=imem_rdata, IF_ID_PC<=PC, IF_ID_Valid<=1; PC<=PC+4 if PCWrite=1; state stays REQ.
REQ-021 In REQ with imem_ack=1 and IF_ID_Write=0: buffer<=imem_rdata and PC, IF/ID holds, PC holds, state<=HOLD.
REQ-022 In REQ with imem_ack=0 and IF_ID_Write=1: IF_ID_Instr<=NOP_INSTR, IF_ID_Valid<=0, PC holds.
REQ-023 In REQ with imem_ack=0 and IF_ID_Write=0: all registers hold.
REQ-024 In HOLD with IF_ID_Write=1: IF/ID<=buffer (Valid=1); PC<=PC+4 if PCWrite=1; state<=REQ.
REQ-025 In HOLD with IF_ID_Write=0: all registers hold, no memory request.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-027 PC SHALL never change except per REQ-019, REQ-020 and REQ-024; one instruction is delivered per PC value, none skipped or duplicated.
REQ-028 Latency: an instruction acked in cycle N SHALL appear on IF_ID_* after the edge ending cycle N when not stalled.

Reset
REQ-029 On reset=1 at a clock edge: PC<=RESET_PC, state<=REQ, IF_ID_Instr<=NOP_INSTR, IF_ID_PC<=0, IF_ID_Valid<=0, buffer cleared; reset mid-HOLD SHALL drop the buffered instruction.
REQ-030 In the first cycle after reset: imem_req=1 and imem_addr=RESET_PC.

Verification
REQ-031 Streaming: ack=1 every cycle, IF_ID_Write=PCWrite=1, rdata=addr-tagged -> IF_ID_PC goes 0,4,8,12 on consecutive cycles, Valid=1.
REQ-032 Load-use stall: after PC=8 is acked, IF_ID_Write=PCWrite=0 for 2 cycles -> HOLD, IF_ID_PC stays 4, then 8 is delivered once and 12 is requested next.
REQ-033 Branch: IF_Flush=1 with BranchTarget=0x40 while the ack for 0x10 is present -> next cycle Valid=0, Instr=0x13, imem_addr=0x40; 0x10 never reaches IF/ID.
REQ-034 Flush during stall: in HOLD with IF_ID_Write=0, IF_Flush=1 with target 0x80 -> buffer dropped, state REQ, imem_addr=0x80.
REQ-035 Memory wait: ack=0 for 3 cycles at PC=0x20 -> 3 bubbles (Valid=0), fetch_busy=1, PC stays 0x20; then 0x20 is delivered.
REQ-036 Reset mid-HOLD plus wrap -> outputs match REQ-029; with RESET_PC=32'hFFFF_FFFC, the second request goes to 0x0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-request fetch FSM (REQ/HOLD), IF/ID pipeline register.
// Latency: instruction acked in cycle N appears on IF_ID_* after the closing edge of cycle N.
// Backpressure: IF_ID_Write=0 parks an acked instruction in a one-entry buffer and drops the request.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IF_ID_Write,
    input  logic        IF_Flush,
    input  logic [31:0] BranchTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic        fetch_busy
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;
    logic [31:0] id_pc_q;
    logic [31:0] id_instr_q;
    logic        id_vld_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            id_pc_q     <= 32'd0;
            id_instr_q  <= NOP_INSTR;
            id_vld_q    <= 1'b0;
        end else if (IF_Flush) begin
            // Redirect wins over any stall; same-cycle memory data is dropped.
            state_q     <= S_REQ;
            pc_q        <= BranchTarget;
            buf_instr_q <= 32'd0;
            buf_pc_q    <= 32'd0;
            id_instr_q  <= NOP_INSTR;
            id_vld_q    <= 1'b0;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ack) begin
                        if (IF_ID_Write) begin
                            id_instr_q <= imem_rdata;
                            id_pc_q    <= pc_q;
                            id_vld_q   <= 1'b1;
                            if (PCWrite) begin
                                pc_q <= pc_q + 32'd4;
                            end
                        end else begin
                            buf_instr_q <= imem_rdata;
                            buf_pc_q    <= pc_q;
                            state_q     <= S_HOLD;
                        end
                    end else if (IF_ID_Write) begin
                        id_instr_q <= NOP_INSTR;
                        id_vld_q   <= 1'b0;
                    end
                end
                S_HOLD: begin
                    // Parked instruction is released only when decode accepts it.
                    if (IF_ID_Write) begin
                        id_instr_q <= buf_instr_q;
                        id_pc_q    <= buf_pc_q;
                        id_vld_q   <= 1'b1;
                        state_q    <= S_REQ;
                        if (PCWrite) begin
                            pc_q <= pc_q + 32'd4;
                        end
                    end
                end
                default: begin
                    state_q <= S_REQ;
                end
            endcase
        end
    end

    assign imem_req    = (state_q == S_REQ);
    assign imem_addr   = pc_q;
    assign fetch_busy  = (state_q == S_REQ) && !imem_ack;
    assign IF_ID_PC    = id_pc_q;
    assign IF_ID_Instr = id_instr_q;
    assign IF_ID_Valid = id_vld_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed table-driven bench for if_stage; a second instance covers the PC wrap from a high reset vector.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, PCWrite, IF_ID_Write, IF_Flush, imem_ack;
    logic [31:0] BranchTarget, imem_rdata;

    logic        req_a, vld_a, busy_a;
    logic [31:0] addr_a, idpc_a, idins_a;
    logic        req_b, vld_b, busy_b;
    logic [31:0] addr_b, idpc_b, idins_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_Flush(IF_Flush), .BranchTarget(BranchTarget),
        .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_ID_PC(idpc_a), .IF_ID_Instr(idins_a), .IF_ID_Valid(vld_a), .fetch_busy(busy_a)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_Flush(IF_Flush), .BranchTarget(BranchTarget),
        .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .IF_ID_PC(idpc_b), .IF_ID_Instr(idins_b), .IF_ID_Valid(vld_b), .fetch_busy(busy_b)
    );

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    typedef struct {
        bit          chk;
        logic        rst, pcw, w, fl;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_busy;
        logic [31:0] e_idpc, e_idins;
        logic        e_vld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit c, input logic rst, input logic pcw, input logic w, input logic fl,
                       input logic [31:0] tgt, input logic ack, input logic e_req,
                       input logic [31:0] e_addr, input logic e_busy, input logic [31:0] e_idpc,
                       input logic [31:0] e_idins, input logic e_vld);
        vec_t v;
        v.chk = c; v.rst = rst; v.pcw = pcw; v.w = w; v.fl = fl; v.tgt = tgt; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_busy = e_busy;
        v.e_idpc = e_idpc; v.e_idins = e_idins; v.e_vld = e_vld;
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b1; PCWrite = 1'b0; IF_ID_Write = 1'b0; IF_Flush = 1'b0;
        BranchTarget = 32'd0; imem_ack = 1'b0; imem_rdata = 32'd0;

        //  chk rst pcw w fl tgt    ack | req addr     busy idpc     idins       vld
        add(0, 1, 0, 0, 0, 32'h0,  0,   0, 32'h0,  0, 32'h0,  NOP,        0);  // reset
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h0,  0, 32'h0,  NOP,        0);  // stream 0
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h4,  0, 32'h0,  tag(32'h0), 1);  // stream 4
        add(1, 0, 0, 0, 0, 32'h0,  1,   1, 32'h8,  0, 32'h4,  tag(32'h4), 1);  // 8 acked, stall
        add(1, 0, 0, 0, 0, 32'h0,  0,   0, 32'h8,  0, 32'h4,  tag(32'h4), 1);  // HOLD, stall
        add(1, 0, 1, 1, 0, 32'h0,  0,   0, 32'h8,  0, 32'h4,  tag(32'h4), 1);  // HOLD release
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'hC,  0, 32'h8,  tag(32'h8), 1);  // 12 requested
        add(1, 0, 1, 1, 1, 32'h40, 1,   1, 32'h10, 0, 32'hC,  tag(32'hC), 1);  // flush over ack 0x10
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h40, 0, 32'hC,  NOP,        0);  // redirected
        add(1, 0, 1, 1, 1, 32'h20, 0,   1, 32'h44, 1, 32'h40, tag(32'h40),1);  // flush to 0x20
        add(1, 0, 1, 1, 0, 32'h0,  0,   1, 32'h20, 1, 32'h40, NOP,        0);  // wait 1
        add(1, 0, 1, 1, 0, 32'h0,  0,   1, 32'h20, 1, 32'h40, NOP,        0);  // wait 2
        add(1, 0, 1, 1, 0, 32'h0,  0,   1, 32'h20, 1, 32'h40, NOP,        0);  // wait 3
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h20, 0, 32'h40, NOP,        0);  // 0x20 acked
        add(1, 0, 0, 0, 0, 32'h0,  0,   1, 32'h24, 1, 32'h20, tag(32'h20),1);  // no ack, stalled
        add(1, 0, 0, 0, 0, 32'h0,  1,   1, 32'h24, 0, 32'h20, tag(32'h20),1);  // park 0x24
        add(1, 0, 0, 0, 1, 32'h80, 0,   0, 32'h24, 0, 32'h20, tag(32'h20),1);  // flush in HOLD
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h80, 0, 32'h20, NOP,        0);  // fetch 0x80
        add(1, 0, 0, 0, 0, 32'h0,  1,   1, 32'h84, 0, 32'h80, tag(32'h80),1);  // park 0x84
        add(1, 1, 1, 1, 0, 32'h0,  0,   0, 32'h84, 0, 32'h80, tag(32'h80),1);  // reset mid-HOLD
        add(1, 0, 1, 1, 0, 32'h0,  0,   1, 32'h0,  1, 32'h0,  NOP,        0);  // after reset
        add(1, 0, 0, 1, 0, 32'h0,  1,   1, 32'h0,  0, 32'h0,  NOP,        0);  // deliver, PC held
        add(1, 0, 1, 1, 0, 32'h0,  1,   1, 32'h0,  0, 32'h0,  tag(32'h0), 1);
        add(1, 0, 1, 1, 0, 32'h0,  0,   1, 32'h4,  1, 32'h0,  tag(32'h0), 1);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst; PCWrite = vecs[i].pcw; IF_ID_Write = vecs[i].w;
            IF_Flush = vecs[i].fl; BranchTarget = vecs[i].tgt; imem_ack = vecs[i].ack;
            imem_rdata = tag(vecs[i].e_addr);
            @(negedge clk);
            if (vecs[i].chk) begin
                chk("imem_req",    i, {31'd0, req_a},  {31'd0, vecs[i].e_req});
                chk("imem_addr",   i, addr_a,          vecs[i].e_addr);
                chk("fetch_busy",  i, {31'd0, busy_a}, {31'd0, vecs[i].e_busy});
                chk("IF_ID_PC",    i, idpc_a,          vecs[i].e_idpc);
                chk("IF_ID_Instr", i, idins_a,         vecs[i].e_idins);
                chk("IF_ID_Valid", i, {31'd0, vld_a},  {31'd0, vecs[i].e_vld});
            end
        end

        // Wrap: instance with RESET_PC=FFFF_FFFC, reset then one delivered fetch.
        @(posedge clk); #1;
        reset = 1'b1; imem_ack = 1'b0; PCWrite = 1'b1; IF_ID_Write = 1'b1; IF_Flush = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; imem_ack = 1'b1; imem_rdata = tag(32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_reset_addr", 100, addr_b, 32'hFFFF_FFFC);
        chk("wrap_reset_req",  100, {31'd0, req_b}, 32'd1);
        chk("wrap_reset_vld",  100, {31'd0, vld_b}, 32'd0);
        @(posedge clk); #1;
        imem_ack = 1'b0;
        @(negedge clk);
        chk("wrap_next_addr",  101, addr_b,  32'h0);
        chk("wrap_idpc",       101, idpc_b,  32'hFFFF_FFFC);
        chk("wrap_idins",      101, idins_b, tag(32'hFFFF_FFFC));
        chk("wrap_vld",        101, {31'd0, vld_b}, 32'd1);
        chk("wrap_busy",       101, {31'd0, busy_b}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
